// File: rtl/game_ctrl.sv
// 2048 board sequencer: owns the 16-tile exponent board, slides/merges one line per
// cycle on a move request, spawns random tiles from a 16-bit LFSR and reports status.
module game_ctrl #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned WIN_EXP   = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        new_game,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  input  logic        load_en,
  input  logic [63:0] load_board,
  input  logic        game_over,
  output logic [63:0] tilevals,
  output logic        move_ready,
  output logic        busy,
  output logic        move_done,
  output logic        moved,
  output logic        won,
  output logic        over
);

  typedef enum logic [2:0] {S_IDLE, S_SLIDE, S_SPAWN, S_CHECK, S_OVER} state_e;

  localparam logic [3:0] WIN_E = 4'(WIN_EXP);

  state_e           state_q, state_d;
  logic [0:15][3:0] board_q, board_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             won_q, won_d, move_done_q, move_done_d, moved_q, moved_d;
  logic [1:0]       spawns_q, spawns_d, dir_q, dir_d, line_q, line_d;
  logic [3:0]       idx_q, idx_d, probes_q, probes_d;
  logic             fresh_q, fresh_d, changed_q, changed_d;

  logic [3:0][3:0]  line_old, line_new;
  logic [3:0]       spawn_idx, spawn_val;
  logic             any_win;

  // Position p of line k in direction d; tile index is {row, col}.
  function automatic logic [3:0] tile_idx(input logic [1:0] d, input logic [1:0] k,
                                          input logic [1:0] p);
    case (d)
      2'd0:    tile_idx = {k, p};
      2'd1:    tile_idx = {k, ~p};
      2'd2:    tile_idx = {p, k};
      default: tile_idx = {~p, k};
    endcase
  endfunction

  // Element 0 is the leading position; compress, then merge pairs once from the front.
  function automatic logic [3:0][3:0] slide_line(input logic [3:0][3:0] in);
    logic [4:0][3:0] c;
    logic [3:0][3:0] m;
    logic [2:0]      n;
    logic [1:0]      w;
    logic            skip;
    c    = '0;
    m    = '0;
    n    = 3'd0;
    w    = 2'd0;
    skip = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (in[i] != 4'd0) begin
        c[n] = in[i];
        n    = n + 3'd1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (c[i] != 4'd0) begin
        if (c[i] == c[i+1] && c[i] != 4'hF) begin
          m[w] = c[i] + 4'd1;
          skip = 1'b1;
        end else begin
          m[w] = c[i];
        end
        w = w + 2'd1;
      end
    end
    return m;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    won_d       = won_q;
    move_done_d = 1'b0;
    moved_d     = moved_q;
    spawns_d    = spawns_q;
    idx_d       = idx_q;
    probes_d    = probes_q;
    fresh_d     = fresh_q;
    dir_d       = dir_q;
    line_d      = line_q;
    changed_d   = changed_q;
    line_old    = '0;
    line_new    = '0;
    spawn_idx   = fresh_q ? lfsr_q[3:0] : idx_q;
    spawn_val   = (lfsr_q[15:13] == 3'd0) ? 4'd2 : 4'd1;
    any_win     = 1'b0;
    for (int i = 0; i < 16; i++) any_win = any_win | (board_q[i] >= WIN_E);

    if (new_game) begin
      board_d   = '0;
      won_d     = 1'b0;
      state_d   = S_SPAWN;
      spawns_d  = 2'd2;
      fresh_d   = 1'b1;
      probes_d  = 4'd0;
      changed_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_OVER: begin
          if (load_en) begin
            board_d   = load_board;
            changed_d = 1'b0;
            state_d   = S_CHECK;
          end else if (move_valid && state_q == S_IDLE) begin
            dir_d     = move_dir;
            line_d    = 2'd0;
            changed_d = 1'b0;
            state_d   = S_SLIDE;
          end
        end
        S_SLIDE: begin
          for (int p = 0; p < 4; p++) line_old[p] = board_q[tile_idx(dir_q, line_q, 2'(p))];
          line_new = slide_line(line_old);
          for (int p = 0; p < 4; p++) board_d[tile_idx(dir_q, line_q, 2'(p))] = line_new[p];
          if (line_new != line_old) changed_d = 1'b1;
          if (line_q == 2'd3) begin
            if (changed_d) begin
              state_d  = S_SPAWN;
              spawns_d = 2'd1;
              fresh_d  = 1'b1;
              probes_d = 4'd0;
            end else begin
              state_d = S_CHECK;
            end
          end else begin
            line_d = line_q + 2'd1;
          end
        end
        S_SPAWN: begin
          // Each spawned tile re-seeds its start index from the running LFSR.
          if (board_q[spawn_idx] == 4'd0) begin
            board_d[spawn_idx] = spawn_val;
            spawns_d = spawns_q - 2'd1;
            fresh_d  = 1'b1;
            probes_d = 4'd0;
            if (spawns_q == 2'd1) state_d = S_CHECK;
          end else begin
            idx_d    = spawn_idx + 4'd1;
            fresh_d  = 1'b0;
            probes_d = probes_q + 4'd1;
            if (probes_q == 4'd15) state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          move_done_d = 1'b1;
          moved_d     = changed_q;
          won_d       = won_q | any_win;
          state_d     = game_over ? S_OVER : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the board is plain
  // flops (not a RAM), so reset clears it in one shot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SPAWN;
      board_q     <= '0;
      lfsr_q      <= LFSR_SEED;
      won_q       <= 1'b0;
      move_done_q <= 1'b0;
      moved_q     <= 1'b0;
      spawns_q    <= 2'd2;
      idx_q       <= 4'd0;
      probes_q    <= 4'd0;
      fresh_q     <= 1'b1;
      dir_q       <= 2'd0;
      line_q      <= 2'd0;
      changed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      lfsr_q      <= lfsr_d;
      won_q       <= won_d;
      move_done_q <= move_done_d;
      moved_q     <= moved_d;
      spawns_q    <= spawns_d;
      idx_q       <= idx_d;
      probes_q    <= probes_d;
      fresh_q     <= fresh_d;
      dir_q       <= dir_d;
      line_q      <= line_d;
      changed_q   <= changed_d;
    end
  end

  assign tilevals   = board_q;
  assign move_ready = (state_q == S_IDLE);
  assign busy       = (state_q == S_SLIDE) || (state_q == S_SPAWN) || (state_q == S_CHECK);
  assign move_done  = move_done_q;
  assign moved      = moved_q;
  assign won        = won_q;
  assign over       = (state_q == S_OVER);

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios plus random moves, compared
// against a queue-based 2048 board model with cycle-exact spawn prediction.
module tb_game_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        new_game = 1'b0;
  logic        move_valid = 1'b0;
  logic [1:0]  move_dir = 2'd0;
  logic        load_en = 1'b0;
  logic [63:0] load_board = '0;
  logic        game_over;
  logic [63:0] tilevals;
  logic        move_ready, busy, move_done, moved, won, over;

  game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game), .move_valid(move_valid),
    .move_dir(move_dir), .load_en(load_en), .load_board(load_board),
    .game_over(game_over), .tilevals(tilevals), .move_ready(move_ready),
    .busy(busy), .move_done(move_done), .moved(moved), .won(won), .over(over)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_fail = 0, n_total = 0;
  int m_b[16];
  bit m_won = 1'b0;
  bit m_over = 1'b0;
  logic [15:0] m_lfsr = SEED;

  function automatic logic [15:0] f_step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Free-running LFSR reference: advances once per clock outside reset.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= f_step(m_lfsr);

  // Environment model of the gamestate block: over when full and no equal neighbours.
  function automatic logic f_go(input logic [63:0] b);
    int t[16];
    for (int i = 0; i < 16; i++) t[i] = int'(b[63-4*i -: 4]);
    for (int i = 0; i < 16; i++) if (t[i] == 0) return 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (c < 3 && t[r*4+c] == t[r*4+c+1]) return 1'b0;
        if (r < 3 && t[r*4+c] == t[r*4+c+4]) return 1'b0;
      end
    return 1'b1;
  endfunction

  always_comb game_over = f_go(tilevals);

  function automatic int nz_count(input logic [63:0] b);
    int n = 0;
    for (int i = 0; i < 16; i++) if (b[63-4*i -: 4] != 4'd0) n++;
    return n;
  endfunction

  function automatic logic [63:0] m_pack();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[63-4*i -: 4] = 4'(m_b[i]);
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_spawn(input logic [15:0] l_in, output logic [15:0] l_out, output int cyc);
    logic [15:0] l;
    int idx;
    l   = l_in;
    idx = int'(l_in[3:0]);
    for (int j = 0; j < 16; j++) begin
      if (m_b[idx] == 0) begin
        m_b[idx] = (l[15:13] == 3'd0) ? 2 : 1;
        cyc      = j + 1;
        l_out    = f_step(l);
        return;
      end
      idx = (idx + 1) % 16;
      l   = f_step(l);
    end
    cyc   = 16;
    l_out = l;
  endtask

  task automatic m_move(input int d, output bit ch);
    int pos[4];
    int v[$];
    int o[$];
    int r, c;
    ch = 1'b0;
    for (int k = 0; k < 4; k++) begin
      v.delete();
      o.delete();
      for (int p = 0; p < 4; p++) begin
        case (d)
          0:       begin r = k;     c = p;     end
          1:       begin r = k;     c = 3 - p; end
          2:       begin r = p;     c = k;     end
          default: begin r = 3 - p; c = k;     end
        endcase
        pos[p] = r * 4 + c;
        if (m_b[pos[p]] != 0) v.push_back(m_b[pos[p]]);
      end
      while (v.size() > 0) begin
        if (v.size() > 1 && v[0] == v[1] && v[0] < 15) begin
          o.push_back(v[0] + 1);
          void'(v.pop_front());
          void'(v.pop_front());
        end else begin
          o.push_back(v.pop_front());
        end
      end
      while (o.size() < 4) o.push_back(0);
      for (int p = 0; p < 4; p++) begin
        if (m_b[pos[p]] != o[p]) ch = 1'b1;
        m_b[pos[p]] = o[p];
      end
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!move_done && n < 300);
  endtask

  task automatic check_done(input string tag, input int exp_lat, input int lat, input bit exp_moved);
    logic [63:0] b;
    logic go;
    b = m_pack();
    for (int i = 0; i < 16; i++) if (m_b[i] >= 11) m_won = 1'b1;
    go = f_go(b);
    m_over = go;
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".board"}, tilevals, b);
    check({tag, ".moved"}, 64'(moved), 64'(exp_moved));
    check({tag, ".over"}, 64'(over), 64'(go));
    check({tag, ".won"}, 64'(won), 64'(m_won));
    check({tag, ".ready"}, 64'(move_ready), 64'(!go));
  endtask

  task automatic do_move(input int d, input bit hold, input string tag);
    logic [15:0] l;
    bit ch;
    int s, n;
    @(negedge clk);
    l = m_lfsr;
    move_valid = 1'b1;
    move_dir = 2'(d);
    @(posedge clk);
    if (hold) @(posedge clk);
    #1 move_valid = 1'b0;
    for (int i = 0; i < 5; i++) l = f_step(l);
    m_move(d, ch);
    s = 0;
    if (ch) m_spawn(l, l, s);
    wait_done(n);
    if (hold) n++;
    check_done(tag, 5 + s, n, ch);
  endtask

  task automatic do_load(input logic [63:0] b, input string tag);
    int n;
    @(negedge clk);
    load_en = 1'b1;
    load_board = b;
    @(posedge clk);
    #1 load_en = 1'b0;
    for (int i = 0; i < 16; i++) m_b[i] = int'(b[63-4*i -: 4]);
    wait_done(n);
    check_done(tag, 1, n, 1'b0);
  endtask

  task automatic do_new(input string tag);
    logic [15:0] l;
    int s1, s2, n;
    @(negedge clk);
    l = m_lfsr;
    new_game = 1'b1;
    move_valid = 1'b1;
    load_en = 1'b1;
    @(posedge clk);
    #1;
    new_game = 1'b0;
    move_valid = 1'b0;
    load_en = 1'b0;
    for (int i = 0; i < 16; i++) m_b[i] = 0;
    m_won = 1'b0;
    l = f_step(l);
    m_spawn(l, l, s1);
    m_spawn(l, l, s2);
    wait_done(n);
    check_done(tag, s1 + s2 + 1, n, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    logic [15:0] l;
    int s1, s2, n;
    rst_n = 1'b0;
    #1;
    check({tag, ".rst_tiles"}, tilevals, 64'd0);
    check({tag, ".rst_flags"}, {59'd0, move_done, moved, won, over, move_ready}, 64'd0);
    @(negedge clk);
    for (int i = 0; i < 16; i++) m_b[i] = 0;
    m_won = 1'b0;
    l = SEED;
    m_spawn(l, l, s1);
    m_spawn(l, l, s2);
    rst_n = 1'b1;
    wait_done(n);
    check_done(tag, s1 + s2 + 1, n, 1'b0);
    check({tag, ".two_tiles"}, 64'(nz_count(tilevals)), 64'd2);
  endtask

  function automatic logic [63:0] rand_board(input bit full);
    logic [63:0] b;
    for (int i = 0; i < 16; i++)
      if (full) b[63-4*i -: 4] = 4'($urandom_range(1, 3));
      else      b[63-4*i -: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 4));
    return b;
  endfunction

  initial begin
    logic [63:0] snap;
    int dones;

    repeat (2) @(posedge clk);
    check("reset.busy", 64'(busy), 64'd1);
    do_reset("reset");
    begin
      bit vals_ok;
      vals_ok = 1'b1;
      for (int i = 0; i < 16; i++)
        if (tilevals[63-4*i -: 4] > 4'd2) vals_ok = 1'b0;
      check("reset.spawn_vals", 64'(vals_ok), 64'd1);
    end

    do_load(64'h1122_0000_0000_0000, "load_1122");
    do_move(0, 1'b0, "left_1122");
    check("left_1122.row0", 64'(tilevals[63:56]), 64'h23);
    check("left_1122.count", 64'(nz_count(tilevals)), 64'd3);

    do_load(64'h1111_0000_0000_0000, "load_1111");
    do_move(0, 1'b0, "left_1111");
    check("left_1111.cols01", 64'(tilevals[63:56]), 64'h22);
    do_load(64'h2210_0000_0000_0000, "load_2210");
    do_move(1, 1'b1, "right_2210");
    check("right_2210.cols23", 64'(tilevals[55:48]), 64'h31);

    do_load(64'hFF00_0000_0000_0000, "load_ff");
    do_move(0, 1'b0, "left_ff");
    check("left_ff.board", tilevals, 64'hFF00_0000_0000_0000);

    do_load(64'h1212_2121_1212_2121, "load_checker");
    check("checker.over", 64'(over), 64'd1);
    snap = tilevals;
    dones = 0;
    @(negedge clk);
    move_valid = 1'b1;
    move_dir = 2'd0;
    repeat (6) begin
      @(posedge clk);
      #1 if (move_done) dones++;
    end
    move_valid = 1'b0;
    check("over_ignored.dones", 64'(dones), 64'd0);
    check("over_ignored.board", tilevals, snap);
    check("over_ignored.over", 64'(over), 64'd1);
    do_new("new_game");
    check("new_game.count", 64'(nz_count(tilevals)), 64'd2);

    do_load(64'h0000_0000_0000_A000, "load_col0");
    do_move(2, 1'b0, "up_col0");
    check("up_col0.tile0", 64'(tilevals[63:60]), 64'hA);
    check("up_col0.count", 64'(nz_count(tilevals)), 64'd2);
    do_load(64'hAA00_0000_0000_0000, "load_aa");
    do_move(0, 1'b0, "left_aa");
    check("left_aa.tile0", 64'(tilevals[63:60]), 64'hB);
    check("left_aa.won", 64'(won), 64'd1);

    for (int it = 0; it < 40; it++) begin
      int r;
      r = int'($urandom_range(0, 11));
      if (r == 0)               do_load(rand_board(1'b0), "rnd_load");
      else if (r == 1)          do_load(rand_board(1'b1), "rnd_full");
      else if (r == 2 || m_over) do_new("rnd_new");
      else                      do_move(int'($urandom_range(0, 3)), 1'b0, "rnd_move");
    end

    do_load(64'h1100_0220_0000_3300, "load_mid");
    @(negedge clk);
    move_valid = 1'b1;
    move_dir = 2'd0;
    @(posedge clk);
    #1 move_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_slide.busy", 64'(busy), 64'd1);
    do_reset("mid_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
